load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Memory-access stage that sits directly downstream of the ALU. It takes the ALU result as the effective address, together with rs2 store data and the size/sign fields from decode. It runs one load or store on a simple word-wide request/ack data bus and returns sign- or zero-extended load data to writeback. It also flags misaligned accesses and bus timeouts.

Parameters:
MEM_TIMEOUT, 255, maximum cycles in MEM waiting for mem_ack before aborting (1..65535)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  access request from execute stage
req_ready  output  1  unit can accept a request (high only in IDLE)
req_we  input  1  1=store, 0=load
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  load zero-extends when 1 (LBU/LHU)
req_addr  input  32  effective address (ALU result)
req_wdata  input  32  store data (rs2)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_misaligned  output  1  valid with resp_valid: misaligned/illegal size
resp_timeout  output  1  valid with resp_valid: bus did not ack
mem_req  output  1  bus request, held until mem_ack
mem_we  output  1  bus write enable
mem_addr  output  32  word address, bits [1:0] always 0
mem_wstrb  output  4  byte strobes; 0000 on loads
mem_wdata  output  32  lane-replicated store data
mem_rdata  input  32  bus read data, sampled on mem_ack
mem_ack  input  1  bus completion, single-cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid, resp_misaligned, resp_timeout, mem_req, mem_we=0; mem_addr, mem_wstrb, mem_wdata, resp_rdata=0; timeout counter=0.
- FSM: IDLE -> MEM or RESP -> IDLE. req_ready = (state==IDLE), combinational from the state register. All other outputs are registered.
- Accept on the clk edge where req_valid & req_ready. Capture addr[1:0], size, unsigned and we internally.
- Misalignment check at accept:
  - Misaligned if size==01 & addr[0], or size==10 & addr[1:0]!=0, or size==11.
  - Misaligned requests go straight to RESP with resp_misaligned=1, resp_rdata=0, and no bus cycle.
- Aligned requests go to MEM:
  - mem_req=1 from the cycle after accept.
  - mem_addr = {addr[31:2],2'b00}; mem_we = req_we.
  - These are held stable until the ack.
- Store strobes and data:
  - Byte: wstrb = 0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - Half: wstrb = 0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - Word: wstrb = 1111, wdata = wdata.
- Loads: wstrb=0000, wdata=0.
- In MEM, on mem_ack:
  - Deassert mem_req on the next edge and go to RESP.
  - For loads, lane = mem_rdata >> (8*addr[1:0]).
  - Byte: resp_rdata = ext(lane[7:0]). Half: resp_rdata = ext(lane[15:0]). Word: full 32 bits.
  - ext is sign-extension unless req_unsigned.
  - Stores return 0.
- Timeout:
  - Counter clears on entry to MEM and increments each MEM cycle without ack.
  - When the count reaches MEM_TIMEOUT without ack, drop mem_req and go to RESP with resp_timeout=1 and resp_rdata=0.
  - If ack arrives in the same cycle the limit is reached, ack wins (normal completion).
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - resp_rdata and flags hold their value until the next RESP; they are meaningful only while resp_valid=1.
- Latency and throughput:
  - Accept at edge N; mem_req visible after N. With ack in the first MEM cycle, resp_valid is high in cycle N+2.
  - Minimum 3 cycles per access; misaligned requests take 2 cycles.
- mem_ack outside MEM is ignored. req_valid outside IDLE is ignored (no queueing).
- rst_n asserted mid-transaction immediately drops mem_req and resp_valid; the transaction is discarded with no response.

Test Plan:
- Word load: addr=0x0000_1004, size=10 → mem_addr=0x1004, wstrb=0000. Ack with rdata=0xDEADBEEF on first MEM cycle → resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF.
- Byte loads: addr=0x2003, rdata=0x80FF_0000. Signed → resp_rdata=0xFFFF_FF80; unsigned → 0x0000_0080. Half signed at addr=0x2002 → 0xFFFF_80FF.
- Byte store: addr=0x3001, wdata=0x1234_56AB → mem_we=1, wstrb=0010, mem_wdata=0xABAB_ABAB. Half store at 0x3002 → wstrb=1100, wdata=0x56AB_56AB.
- Misaligned: word at 0x4002, half at 0x4001 and size=11 → each gives resp_misaligned=1, resp_rdata=0 and no mem_req pulse. req_ready is low for exactly 1 cycle.
- Timeout with MEM_TIMEOUT=4 and no ack → mem_req high exactly 4 cycles, then resp_valid with resp_timeout=1. Repeat with ack in the 4th cycle → normal completion, resp_timeout=0.
- Reset mid-MEM: assert rst_n=0 while mem_req=1 → mem_req=0 asynchronously and no resp_valid. After release, req_ready=1 and a fresh load completes normally; a late mem_ack in IDLE is ignored.

Source files
------------

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Signal bundle between the execute stage, the load/store unit
//               and the word-wide request/ack data bus.
//               master : environment view (execute stage + memory model)
//               slave  : load/store unit view
//               Request  : req_valid/req_ready/req_we/req_size/req_unsigned/
//                          req_addr/req_wdata
//               Response : resp_valid/resp_rdata/resp_misaligned/resp_timeout
//               Bus      : mem_req/mem_we/mem_addr/mem_wstrb/mem_wdata/
//                          mem_rdata/mem_ack
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_timeout;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output mem_rdata, mem_ack,
        input  req_ready, resp_valid, resp_rdata, resp_misaligned, resp_timeout,
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  mem_rdata, mem_ack,
        output req_ready, resp_valid, resp_rdata, resp_misaligned, resp_timeout,
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Memory-access stage. Accepts one load/store at a time from
//               execute, checks alignment, runs a single request/ack bus
//               cycle with lane-replicated store data and byte strobes, and
//               returns sign/zero-extended load data. Bus cycles that are not
//               acknowledged within MEM_TIMEOUT cycles are aborted.
//               Ports: clk, rst_n (async, active low), bus (slave modport of
//               load_store_unit_if: request, response and data-bus groups).
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    localparam logic [1:0]  c_IDLE         = 2'd0;
    localparam logic [1:0]  c_MEM          = 2'd1;
    localparam logic [1:0]  c_RESP         = 2'd2;
    // Counter value at the start of the last MEM cycle allowed before abort.
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(MEM_TIMEOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;

    logic        r_we;
    logic        r_unsigned;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic [15:0] r_cnt;

    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_mis;
    logic        r_resp_to;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_mem_wdata;

    logic        w_misaligned;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_lane;
    logic [31:0] w_load_data;
    logic        w_timeout_hit;

    assign bus.req_ready       = (r_state == c_IDLE);
    assign bus.resp_valid      = r_resp_valid;
    assign bus.resp_rdata      = r_resp_rdata;
    assign bus.resp_misaligned = r_resp_mis;
    assign bus.resp_timeout    = r_resp_to;
    assign bus.mem_req         = r_mem_req;
    assign bus.mem_we          = r_mem_we;
    assign bus.mem_addr        = r_mem_addr;
    assign bus.mem_wstrb       = r_mem_wstrb;
    assign bus.mem_wdata       = r_mem_wdata;

    // Alignment check plus store strobes/lane replication for the request
    // currently presented on the request port.
    always_comb begin
        w_misaligned = 1'b0;
        w_wstrb      = 4'b0000;
        w_wdata      = 32'h0;
        case (bus.req_size)
            2'b00: begin
                w_wstrb = 4'b0001 << bus.req_addr[1:0];
                w_wdata = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_misaligned = bus.req_addr[0];
                w_wstrb      = 4'b0011 << bus.req_addr[1:0];
                w_wdata      = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                w_misaligned = |bus.req_addr[1:0];
                w_wstrb      = 4'b1111;
                w_wdata      = bus.req_wdata;
            end
            default: w_misaligned = 1'b1;
        endcase
        if (!bus.req_we) begin
            w_wstrb = 4'b0000;
            w_wdata = 32'h0;
        end
    end

    // Load lane selection and extension from the captured offset/size.
    always_comb begin
        w_lane = bus.mem_rdata >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_load_data = {{24{w_lane[7]  & ~r_unsigned}}, w_lane[7:0]};
            2'b01:   w_load_data = {{16{w_lane[15] & ~r_unsigned}}, w_lane[15:0]};
            default: w_load_data = w_lane;  // only word size reaches MEM here
        endcase
        if (r_we) begin
            w_load_data = 32'h0;
        end
    end

    assign w_timeout_hit = (r_cnt == c_TIMEOUT_LAST);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.req_valid) begin
                    w_next_state = w_misaligned ? c_RESP : c_MEM;
                end
            end
            // ack has priority over the timeout limit in the same cycle
            c_MEM: begin
                if (bus.mem_ack || w_timeout_hit) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_cnt        <= 16'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_mis   <= 1'b0;
            r_resp_to    <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'h0;
            r_mem_wstrb  <= 4'b0000;
            r_mem_wdata  <= 32'h0;
        end else begin
            // One-cycle pulse: high exactly while the FSM sits in RESP.
            r_resp_valid <= (w_next_state == c_RESP);
            case (r_state)
                c_IDLE: begin
                    if (bus.req_valid) begin
                        r_we       <= bus.req_we;
                        r_unsigned <= bus.req_unsigned;
                        r_size     <= bus.req_size;
                        r_off      <= bus.req_addr[1:0];
                        if (w_misaligned) begin
                            r_resp_mis   <= 1'b1;
                            r_resp_to    <= 1'b0;
                            r_resp_rdata <= 32'h0;
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= bus.req_we;
                            r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                            r_mem_wstrb <= w_wstrb;
                            r_mem_wdata <= w_wdata;
                            r_cnt       <= 16'h0;
                        end
                    end
                end
                c_MEM: begin
                    if (bus.mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_resp_rdata <= w_load_data;
                        r_resp_mis   <= 1'b0;
                        r_resp_to    <= 1'b0;
                    end else if (w_timeout_hit) begin
                        r_mem_req    <= 1'b0;
                        r_resp_rdata <= 32'h0;
                        r_resp_mis   <= 1'b0;
                        r_resp_to    <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench for load_store_unit (MEM_TIMEOUT = 4).
//               Directed scenarios followed by randomized accesses, each
//               compared against a byte-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_TMO = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(
        .MEM_TIMEOUT (c_TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed running expected done");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Byte-lane reference: works from sizes in bytes and address offsets.
    task automatic model(input bit we, input bit [1:0] size, input bit uns,
                         input bit [31:0] addr, input bit [31:0] wdata, input bit [31:0] rdata,
                         output bit mis, output bit [31:0] e_addr, output bit [3:0] e_strb,
                         output bit [31:0] e_wdata, output bit [31:0] e_rdata);
        int     off;
        int     nbytes;
        longint v;
        off     = int'(addr % 4);
        e_addr  = addr - 32'(off);
        e_strb  = 4'b0000;
        e_wdata = 32'h0;
        e_rdata = 32'h0;
        if (size == 2'd3) begin
            mis = 1'b1;
        end else begin
            nbytes = 1 << size;
            mis    = (off % nbytes) != 0;
            if (!mis && we) begin
                for (int i = 0; i < 4; i++) begin
                    if (i >= off && i < off + nbytes) e_strb[i] = 1'b1;
                    e_wdata[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
                end
            end
            if (!mis && !we) begin
                v = 0;
                for (int i = 0; i < nbytes; i++)
                    v = v | (longint'(rdata[8*(off+i) +: 8]) << (8*i));
                if (!uns && v[8*nbytes-1]) v = v - (longint'(1) << (8*nbytes));
                e_rdata = v[31:0];
            end
        end
    endtask

    // Runs one access. Entered and left #1 after a rising edge with the unit
    // idle. ack_at: MEM cycle index (0 = first) that gets mem_ack; anything
    // outside 0..c_TMO-1 means the bus never answers in time.
    task automatic access(input bit we, input bit [1:0] size, input bit uns,
                          input bit [31:0] addr, input bit [31:0] wdata, input bit [31:0] rdata,
                          input int ack_at, input string tag);
        bit        mis;
        bit [31:0] e_addr;
        bit [31:0] e_wdata;
        bit [31:0] e_rdata;
        bit [3:0]  e_strb;
        bit        exp_to;
        int        exp_cycles;
        int        mem_cycles;
        bit        got;
        model(we, size, uns, addr, wdata, rdata, mis, e_addr, e_strb, e_wdata, e_rdata);
        check({tag, "/ready_idle"}, bus.req_ready, 1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr  = $urandom();
        bus.req_wdata = $urandom();
        bus.req_size  = 2'($urandom_range(0, 3));
        check({tag, "/ready_busy"}, bus.req_ready, 0);
        if (mis) begin
            check({tag, "/mis_valid"}, bus.resp_valid, 1);
            check({tag, "/mis_flag"}, bus.resp_misaligned, 1);
            check({tag, "/mis_to"}, bus.resp_timeout, 0);
            check({tag, "/mis_rdata"}, bus.resp_rdata, 0);
            check({tag, "/mis_nobus"}, bus.mem_req, 0);
            @(posedge clk); #1;
            check({tag, "/mis_nobus2"}, bus.mem_req, 0);
        end else begin
            check({tag, "/no_early_resp"}, bus.resp_valid, 0);
            check({tag, "/mem_req"}, bus.mem_req, 1);
            check({tag, "/mem_we"}, bus.mem_we, 32'(we));
            check({tag, "/mem_addr"}, bus.mem_addr, e_addr);
            check({tag, "/mem_wstrb"}, bus.mem_wstrb, 32'(e_strb));
            check({tag, "/mem_wdata"}, bus.mem_wdata, e_wdata);
            exp_to     = (ack_at < 0) || (ack_at >= c_TMO);
            exp_cycles = exp_to ? c_TMO : ack_at + 1;
            mem_cycles = 0;
            got        = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                if (bus.mem_req) begin
                    mem_cycles++;
                    check({tag, "/addr_hold"}, bus.mem_addr, e_addr);
                end
                bus.mem_ack   = (k == ack_at);
                bus.mem_rdata = (k == ack_at) ? rdata : $urandom();
                @(posedge clk); #1;
                bus.mem_ack = 1'b0;
                if (bus.resp_valid) got = 1'b1;
            end
            check({tag, "/resp_seen"}, 32'(got), 1);
            check({tag, "/mem_cycles"}, mem_cycles, exp_cycles);
            check({tag, "/req_dropped"}, bus.mem_req, 0);
            check({tag, "/resp_mis"}, bus.resp_misaligned, 0);
            check({tag, "/resp_to"}, bus.resp_timeout, 32'(exp_to));
            check({tag, "/resp_rdata"}, bus.resp_rdata, exp_to ? 32'h0 : e_rdata);
            @(posedge clk); #1;
        end
        check({tag, "/pulse_end"}, bus.resp_valid, 0);
        check({tag, "/ready_back"}, bus.req_ready, 1);
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        bus.mem_rdata    = 32'h0;
        bus.mem_ack      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst/ready", bus.req_ready, 1);
        check("rst/resp_valid", bus.resp_valid, 0);
        check("rst/resp_mis", bus.resp_misaligned, 0);
        check("rst/resp_to", bus.resp_timeout, 0);
        check("rst/resp_rdata", bus.resp_rdata, 0);
        check("rst/mem_req", bus.mem_req, 0);
        check("rst/mem_we", bus.mem_we, 0);
        check("rst/mem_addr", bus.mem_addr, 0);
        check("rst/mem_wstrb", bus.mem_wstrb, 0);
        check("rst/mem_wdata", bus.mem_wdata, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios
        access(0, 2'b10, 0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, "lw");
        access(0, 2'b00, 0, 32'h0000_2003, 32'h0, 32'h80FF_0000, 0, "lb");
        access(0, 2'b00, 1, 32'h0000_2003, 32'h0, 32'h80FF_0000, 1, "lbu");
        access(0, 2'b01, 0, 32'h0000_2002, 32'h0, 32'h80FF_0000, 2, "lh");
        access(0, 2'b01, 1, 32'h0000_2002, 32'h0, 32'h80FF_0000, 0, "lhu");
        access(1, 2'b00, 0, 32'h0000_3001, 32'h1234_56AB, 32'hFFFF_FFFF, 0, "sb");
        access(1, 2'b01, 0, 32'h0000_3002, 32'h1234_56AB, 32'hFFFF_FFFF, 1, "sh");
        access(1, 2'b10, 0, 32'h0000_3008, 32'h1234_56AB, 32'hFFFF_FFFF, 0, "sw");
        access(0, 2'b10, 0, 32'h0000_4002, 32'h0, 32'h0, 0, "mis_w");
        access(0, 2'b01, 0, 32'h0000_4001, 32'h0, 32'h0, 0, "mis_h");
        access(1, 2'b11, 0, 32'h0000_4000, 32'h0, 32'h0, 0, "mis_sz");
        access(0, 2'b10, 0, 32'h0000_5000, 32'h0, 32'h1111_2222, -1, "tmo");
        access(0, 2'b10, 0, 32'h0000_5000, 32'h0, 32'h1111_2222, c_TMO - 1, "ack_at_limit");
        access(1, 2'b10, 0, 32'h0000_5004, 32'hCAFE_F00D, 32'h0, -1, "tmo_st");

        // Reset in the middle of a bus cycle
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_6000;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("rstmid/mem_req_up", bus.mem_req, 1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("rstmid/mem_req_async", bus.mem_req, 0);
        check("rstmid/no_resp", bus.resp_valid, 0);
        check("rstmid/ready", bus.req_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h7777_7777;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        check("late_ack/no_resp", bus.resp_valid, 0);
        check("late_ack/no_req", bus.mem_req, 0);
        check("late_ack/ready", bus.req_ready, 1);
        access(0, 2'b00, 0, 32'h0000_6001, 32'h0, 32'h0000_9C00, 0, "post_rst");

        // Randomized accesses
        for (int n = 0; n < 60; n++) begin
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   $urandom(), $urandom(), $urandom(), int'($urandom_range(0, 5)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
